// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ edge-triggered requesters.
// Each rising request edge queues one byte; queued bytes launch one at a time via start/busy.
module uart_tx_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_lvl,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  input  logic                     tx_busy,
  output logic                     tx_start,
  output logic [DATA_W-1:0]        tx_data,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic [N_REQ-1:0]         pending,
  output logic [N_REQ-1:0]         overrun,
  output logic                     ack_err
);

  localparam int unsigned    IdW      = $clog2(N_REQ);
  localparam logic [IdW-1:0] LastId   = IdW'(N_REQ - 1);
  localparam logic [7:0]     AckLimit = 8'(ACK_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StWaitAck, StWaitDone} state_e;

  state_e              state_q;
  logic [N_REQ-1:0]    dly_q;
  logic [N_REQ-1:0]    req_edge;
  logic [N_REQ-1:0]    grant_clr;
  logic [DATA_W-1:0]   hold_q [N_REQ];
  logic [IdW-1:0]      rr_ptr_q;
  logic [IdW-1:0]      rr_next;
  logic [IdW-1:0]      win_id;
  logic                win_valid;
  logic                launch;
  logic [7:0]          timer_q;
  logic [31:0]         idx;

  assign req_edge = req_lvl & ~dly_q;

  // Scan from the farthest offset down so the index closest to rr_ptr wins last.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      idx = (32'(rr_ptr_q) + unsigned'(k)) % N_REQ;
      if (pending[IdW'(idx)]) begin
        win_valid = 1'b1;
        win_id    = IdW'(idx);
      end
    end
  end

  always_comb begin
    launch  = (state_q == StIdle) && win_valid && !tx_busy;
    rr_next = (win_id == LastId) ? '0 : win_id + 1'b1;
    for (int i = 0; i < int'(N_REQ); i++) begin
      grant_clr[i] = launch && (win_id == IdW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      timer_q  <= '0;
      tx_start <= 1'b0;
      tx_data  <= '0;
      grant_id <= '0;
      pending  <= '0;
      overrun  <= '0;
      ack_err  <= 1'b0;
      // A line already high at reset release must not look like a fresh edge.
      dly_q    <= req_lvl;
      for (int i = 0; i < int'(N_REQ); i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      dly_q    <= req_lvl;
      tx_start <= 1'b0;
      ack_err  <= 1'b0;

      // An edge landing on the grant cycle re-queues with fresh data instead of overrunning.
      for (int i = 0; i < int'(N_REQ); i++) begin
        overrun[i] <= req_edge[i] & pending[i] & ~grant_clr[i];
        if (req_edge[i] && (!pending[i] || grant_clr[i])) begin
          pending[i] <= 1'b1;
          hold_q[i]  <= req_data[i*DATA_W +: DATA_W];
        end else if (grant_clr[i]) begin
          pending[i] <= 1'b0;
        end
      end

      case (state_q)
        StIdle: begin
          if (launch) begin
            tx_start <= 1'b1;
            tx_data  <= hold_q[win_id];
            grant_id <= win_id;
            rr_ptr_q <= rr_next;
            timer_q  <= '0;
            state_q  <= StWaitAck;
          end
        end
        StWaitAck: begin
          if (tx_busy) begin
            state_q <= StWaitDone;
          end else if (timer_q == AckLimit) begin
            // The byte is dropped; the requester must raise a new edge to retry.
            ack_err <= 1'b1;
            state_q <= StIdle;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        StWaitDone: begin
          if (!tx_busy) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (N_REQ=4, DATA_W=8, ACK_TIMEOUT=15).
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_lvl;
  logic [31:0] req_data;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;
  logic [3:0]  pending;
  logic [3:0]  overrun;
  logic        ack_err;

  int checks   = 0;
  int failures = 0;
  bit model_en = 1'b1;
  int busy_cnt = 0;

  uart_tx_arbiter #(
    .N_REQ      (4),
    .DATA_W     (8),
    .ACK_TIMEOUT(15)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req_lvl (req_lvl),
    .req_data(req_data),
    .tx_busy (tx_busy),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .grant_id(grant_id),
    .pending (pending),
    .overrun (overrun),
    .ack_err (ack_err)
  );

  always #5 clk = ~clk;

  // UART model: busy rises one cycle after tx_start and stays high for 20 cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (model_en) begin
        tx_busy = (busy_cnt != 0);
        if (tx_start) busy_cnt = 20;
        else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
      end else begin
        busy_cnt = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] d);
    req_data[i*8 +: 8] = d;
    req_lvl[i]         = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic wait_launch(input string tag, input int max_cyc);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (tx_start !== 1'b1 && n < max_cyc);
    check(tag, 32'(tx_start), 32'd1);
  endtask

  task automatic count_launches(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (tx_start === 1'b1) cnt++;
    end
  endtask

  task automatic wait_busy_low(input int max_cyc);
    int n;
    n = 0;
    while (tx_busy !== 1'b0 && n < max_cyc) begin
      step();
      n++;
    end
  endtask

  int n;
  int cnt;

  initial begin
    rst      = 1'b1;
    req_lvl  = '0;
    req_data = '0;
    tx_busy  = 1'b0;

    // Reset state
    step();
    step();
    check("rst_tx_start", 32'(tx_start), 32'd0);
    rst = 1'b0;
    step();
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_flags", {30'd0, ack_err, |overrun}, 32'd0);

    // Single request: two-cycle latency
    set_req(2, 8'h41);
    step();
    check("t1_pending", 32'(pending), 32'h4);
    check("t1_no_early_start", 32'(tx_start), 32'd0);
    step();
    check("t1_start", 32'(tx_start), 32'd1);
    check("t1_data", 32'(tx_data), 32'h41);
    check("t1_grant", 32'(grant_id), 32'd2);
    check("t1_pending_clr", 32'(pending), 32'd0);
    step();
    req_lvl[2] = 1'b0;
    check("t1_one_cycle", 32'(tx_start), 32'd0);
    step();
    step();
    check("t1_busy_seen", 32'(tx_busy), 32'd1);
    wait_busy_low(40);
    step();
    step();
    check("t1_idle", 32'(dut.state_q), 32'd0);
    check("t1_data_held", 32'(tx_data), 32'h41);

    // Simultaneous requests, twice: order 0,1,3 both times
    do_reset();
    for (int r = 0; r < 2; r++) begin
      set_req(0, 8'h10);
      set_req(1, 8'h11);
      set_req(3, 8'h13);
      wait_launch("t2_launch_a", 10);
      check("t2_grant_a", 32'(grant_id), 32'd0);
      check("t2_data_a", 32'(tx_data), 32'h10);
      req_lvl = '0;
      wait_launch("t2_launch_b", 40);
      check("t2_grant_b", 32'(grant_id), 32'd1);
      check("t2_data_b", 32'(tx_data), 32'h11);
      wait_launch("t2_launch_c", 40);
      check("t2_grant_c", 32'(grant_id), 32'd3);
      check("t2_data_c", 32'(tx_data), 32'h13);
      step();
      wait_busy_low(40);
      step();
      step();
    end

    // Overrun while the transmitter is busy with another byte
    do_reset();
    set_req(0, 8'hA0);
    wait_launch("t3_filler", 10);
    req_lvl[0] = 1'b0;
    step();
    step();
    step();
    set_req(1, 8'h55);
    step();
    check("t3_pending", 32'(pending), 32'h2);
    check("t3_no_overrun_yet", 32'(overrun), 32'd0);
    req_lvl[1] = 1'b0;
    step();
    set_req(1, 8'h66);
    step();
    check("t3_overrun", 32'(overrun), 32'h2);
    step();
    check("t3_overrun_pulse", 32'(overrun), 32'd0);
    req_lvl[1] = 1'b0;
    wait_launch("t3_launch", 40);
    check("t3_grant", 32'(grant_id), 32'd1);
    check("t3_data", 32'(tx_data), 32'h55);
    count_launches(40, cnt);
    check("t3_single_launch", 32'(cnt), 32'd0);
    check("t3_pending_end", 32'(pending), 32'd0);

    // Line held high through reset release
    set_req(0, 8'h77);
    do_reset();
    count_launches(10, cnt);
    check("t4_no_launch", 32'(cnt), 32'd0);
    check("t4_no_pending", 32'(pending), 32'd0);
    req_lvl = '0;
    step();

    // Reset during WAIT_DONE
    set_req(2, 8'h5A);
    wait_launch("t4_launch", 10);
    req_lvl = '0;
    step();
    step();
    step();
    step();
    check("t4_wait_done", 32'(dut.state_q), 32'd2);
    rst = 1'b1;
    step();
    check("t4_rst_state", 32'(dut.state_q), 32'd0);
    check("t4_rst_data", 32'(tx_data), 32'd0);
    check("t4_rst_grant", 32'(grant_id), 32'd0);
    check("t4_rst_flags", {27'd0, tx_start, ack_err, pending == 4'd0, overrun == 4'd0, 1'b0},
          32'h6);
    rst = 1'b0;
    wait_busy_low(40);
    step();

    // Ack timeout with busy tied low
    model_en = 1'b0;
    tx_busy  = 1'b0;
    do_reset();
    set_req(3, 8'h33);
    step();
    step();
    check("t5_start", 32'(tx_start), 32'd1);
    check("t5_grant", 32'(grant_id), 32'd3);
    check("t5_data", 32'(tx_data), 32'h33);
    req_lvl = '0;
    n = 0;
    do begin
      step();
      n++;
    end while (ack_err !== 1'b1 && n < 30);
    check("t5_ack_err_delay", 32'(n), 32'd16);
    step();
    check("t5_ack_err_pulse", 32'(ack_err), 32'd0);
    check("t5_pending", 32'(pending), 32'd0);
    count_launches(20, cnt);
    check("t5_no_retry", 32'(cnt), 32'd0);

    // Edge on requester 2 in the very cycle its first byte is granted
    tx_busy = 1'b1;
    do_reset();
    set_req(2, 8'h21);
    step();
    check("t6_pending", 32'(pending), 32'h4);
    req_lvl[2] = 1'b0;
    step();
    step();
    tx_busy = 1'b0;
    set_req(2, 8'h22);
    step();
    check("t6_start", 32'(tx_start), 32'd1);
    check("t6_data_first", 32'(tx_data), 32'h21);
    check("t6_pending_kept", 32'(pending), 32'h4);
    check("t6_no_overrun", 32'(overrun), 32'd0);
    tx_busy    = 1'b1;
    req_lvl[2] = 1'b0;
    step();
    check("t6_no_overrun_late", 32'(overrun), 32'd0);
    step();
    step();
    tx_busy = 1'b0;
    wait_launch("t6_second_launch", 10);
    check("t6_grant_second", 32'(grant_id), 32'd2);
    check("t6_data_second", 32'(tx_data), 32'h22);
    check("t6_pending_end", 32'(pending), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between N_REQ front-panel request lines (debounced Basys3 buttons or switch strobes). Each line's rising edge is detected internally and queues that requester's byte; a round-robin scheduler launches queued bytes one at a time through the transmitter's start/busy handshake. It sits between the input-conditioning logic and the UART TX core.

## Interface
- N_REQ, 4: number of requesters, 2..8
- DATA_W, 8: byte width per requester
- ACK_TIMEOUT, 15: cycles to wait for tx_busy after tx_start, 1..255
- clk  in  1  system clock; all logic is on posedge
- rst  in  1  synchronous, active-high reset
- req_lvl  in  N_REQ  level request lines, already synchronized and debounced
- req_data  in  N_REQ*DATA_W  byte for requester i at [i*DATA_W +: DATA_W]
- tx_busy  in  1  UART TX busy, high while a frame is shifting
- tx_start  out  1  one-cycle launch pulse to UART TX
- tx_data  out  DATA_W  byte for the TX; valid while tx_start=1, held until the next launch
- grant_id  out  $clog2(N_REQ)  requester of the current/last launch
- pending  out  N_REQ  per-requester queued flag
- overrun  out  N_REQ  one-cycle pulse: edge dropped because that requester was already pending
- ack_err  out  1  one-cycle pulse: ACK_TIMEOUT expired without tx_busy

## Operation
- Edge detect per line: dly[i] <= req_lvl[i] each cycle; edge[i] = req_lvl[i] & ~dly[i]. During rst, dly loads req_lvl, so a line held high across reset release produces no edge.
- On edge[i] with pending[i]=0: pending[i] <= 1 and hold[i] <= req_data slice i.
- On edge[i] with pending[i]=1: hold[i] unchanged, overrun[i] pulses.
- Same-cycle edge[i] and grant-clear of i: the edge wins; pending[i] stays 1 and hold[i] takes the new data; no overrun.
- Round robin: rr_ptr (reset 0) is the highest-priority index. The winner is the first pending index at or after rr_ptr, modulo N_REQ. After granting w, rr_ptr <= (w+1) mod N_REQ.
- FSM states:
  - IDLE: if pending != 0 and tx_busy = 0, register tx_start=1, tx_data=hold[w], grant_id=w; clear pending[w]; go to WAIT_ACK with the timer at 0.
  - WAIT_ACK: if tx_busy=1, go to WAIT_DONE. Otherwise increment the timer; when the timer reaches ACK_TIMEOUT, pulse ack_err and return to IDLE. The byte is dropped, not requeued.
  - WAIT_DONE: if tx_busy=0, go to IDLE.
- No launch occurs outside IDLE. Edges continue to be captured in every state.
- Reset (synchronous): state IDLE, rr_ptr 0, timer 0, and all outputs 0 (tx_start, tx_data, grant_id, pending, overrun, ack_err). hold is cleared to 0. Reset mid-frame abandons the frame; the TX core's own reset handles its side.

## Timing
- req_lvl[i] sampled rising at posedge k leads to pending[i]=1 after posedge k.
- If IDLE and tx_busy=0, tx_start is high in the cycle after posedge k+1. Request-to-launch latency is 2 cycles.
- tx_start is exactly one cycle wide. tx_data and grant_id change only at a launch.
- Back-to-back launches: the next tx_start comes no earlier than 1 cycle after tx_busy falls (one IDLE cycle).
- ack_err is asserted in the cycle after the timer reaches ACK_TIMEOUT, i.e. ACK_TIMEOUT+1 cycles after tx_start.
- overrun[i] is high in the cycle after the offending edge is sampled.
- pending reflects registered state. A pending bit clears in the same cycle tx_start rises.

## Test plan
- Single request: req 2 rises with data 0x41, tx_busy model goes high 1 cycle after start for 20 cycles. Expect tx_start 2 cycles after the edge, tx_data 0x41, grant_id 2, pending 0000 after the launch, FSM back in IDLE after busy falls.
- Simultaneous: reqs 0, 1, 3 rise in the same cycle with data 0x10, 0x11, 0x13. Expect launch order 0, 1, 3. Next the same three rise again and expect order 0, 1, 3 again (rr_ptr at 0 after granting 3).
- Overrun: req 1 rises with data 0x55 while tx_busy=1, falls, then rises with 0x66 before being granted. Expect an overrun[1] pulse and a single launch of 0x55.
- Reset behaviour: req 0 held high through rst release. Expect no pending and no launch. Assert rst during WAIT_DONE and expect all outputs 0 and the FSM in IDLE the next cycle.
- Timeout: tx_busy tied 0, req 3 rises, ACK_TIMEOUT=15. Expect tx_start, then an ack_err pulse 16 cycles later, and pending[3]=0 with no retry.
- Edge/clear collision: req 2 rises a second time (data 0x22) in the exact cycle it is granted its first byte. Expect pending[2] to remain 1, no overrun, and 0x22 sent as the following launch.
